// File: rtl/fetch_buffer_if.sv
// Fetch-side bundle between the core and the fetch buffer: PC control,
// instruction-memory request/response and the decoder handshake.
interface fetch_buffer_if;
    logic [7:0] fetch_pc;
    logic       flush;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_rvalid;
    logic [7:0] imem_rdata;
    logic       pc_hold;
    logic       dec_valid;
    logic [7:0] dec_instr;
    logic [7:0] dec_pc;
    logic       dec_ready;

    // master: surrounding core and memory; slave: the fetch buffer itself
    modport master (
        output fetch_pc, flush, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, pc_hold, dec_valid, dec_instr, dec_pc
    );

    modport slave (
        input  fetch_pc, flush, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, pc_hold, dec_valid, dec_instr, dec_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: credit-limited memory requests, in-order tag queue,
// and a {pc, instr} FIFO feeding the decoder; flushes drop in-flight responses.
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] fifo_wr_q, fifo_wr_d;
    logic [CW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] tag_wr_q, tag_wr_d;
    logic [CW-1:0] tag_rd_q, tag_rd_d;

    logic [7:0] fifo_pc_q    [DEPTH];
    logic [7:0] fifo_instr_q [DEPTH];
    logic [7:0] tag_pc_q     [DEPTH];

    logic [DEPTH-1:0] fifo_head_hit;
    logic [DEPTH-1:0] tag_head_hit;
    logic [7:0]       head_pc;
    logic [7:0]       head_instr;
    logic [7:0]       tag_head;

    logic [CW:0] in_use;
    logic        credit_ok;
    logic        issue;
    logic        rsp_ok;
    logic        push;
    logic        stale;
    logic        pop;
    logic        dec_valid_int;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
    endfunction

    // Entries held plus requests still owed by memory must never exceed DEPTH
    assign in_use    = {1'b0, occ_q} + {1'b0, out_q};
    assign credit_ok = in_use < (CW+1)'(DEPTH);
    assign issue     = !bus.flush && credit_ok;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_ok        = bus.imem_rvalid && (out_q != '0);
    assign push          = rsp_ok && !bus.flush && (disc_q == '0);
    assign stale         = rsp_ok && (bus.flush || (disc_q != '0));
    assign dec_valid_int = (occ_q != '0);
    assign pop           = dec_valid_int && bus.dec_ready && !bus.flush;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_head_sel
        assign fifo_head_hit[gi] = (fifo_rd_q == CW'(gi));
        assign tag_head_hit[gi]  = (tag_rd_q == CW'(gi));
    end

    always_comb begin
        head_pc    = '0;
        head_instr = '0;
        tag_head   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_head_hit[i]) begin
                head_pc    = fifo_pc_q[i];
                head_instr = fifo_instr_q[i];
            end
            if (tag_head_hit[i]) begin
                tag_head = tag_pc_q[i];
            end
        end
    end

    always_comb begin
        occ_d     = occ_q;
        disc_d    = disc_q;
        fifo_wr_d = fifo_wr_q;
        fifo_rd_d = fifo_rd_q;
        tag_wr_d  = issue  ? ptr_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d  = rsp_ok ? ptr_inc(tag_rd_q) : tag_rd_q;
        out_d     = out_q + CW'(issue) - CW'(rsp_ok);

        if (bus.flush) begin
            // Everything still owed after this cycle belongs to the wrong path
            occ_d     = '0;
            fifo_rd_d = fifo_wr_q;
            disc_d    = out_q - CW'(rsp_ok);
        end else begin
            if (push) begin
                fifo_wr_d = ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
            if (stale) begin
                disc_d = disc_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q     <= '0;
            out_q     <= '0;
            disc_q    <= '0;
            fifo_wr_q <= '0;
            fifo_rd_q <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
        end else begin
            occ_q     <= occ_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            fifo_wr_q <= fifo_wr_d;
            fifo_rd_q <= fifo_rd_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
        end
    end

    // Storage carries no reset; validity is tracked by the counters above
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && (tag_wr_q == CW'(i))) begin
                tag_pc_q[i] <= bus.fetch_pc;
            end
            if (push && (fifo_wr_q == CW'(i))) begin
                fifo_pc_q[i]    <= tag_head;
                fifo_instr_q[i] <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req  = reset && issue;
    assign bus.pc_hold   = !bus.imem_req;
    assign bus.imem_addr = bus.fetch_pc;
    assign bus.dec_valid = dec_valid_int;
    assign bus.dec_instr = dec_valid_int ? head_instr : 8'h00;
    assign bus.dec_pc    = dec_valid_int ? head_pc    : 8'h00;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: a memory/PC model drives stimulus and
// queues expected decoder entries; a negedge monitor pops and compares.
module tb_fetch_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    fetch_buffer_if bus();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        int         epoch;
        int         due;
    } req_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
    } ent_t;

    req_t inflight[$];
    ent_t exp_q[$];

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         epoch    = 0;
    int         last_due = 0;
    int         lat_min  = 1;
    int         lat_max  = 1;
    int         p_err    = 0;
    logic [7:0] pc_m     = 8'h00;
    logic [7:0] flush_tgt = 8'h00;
    bit         exp_req_v = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock interval: account for what the last edge did, then drive new inputs
    task automatic cycle(input bit fl, input bit rdy, input logic [7:0] tgt);
        req_t r;
        ent_t e;
        int   lat;
        @(posedge clk);
        #1;
        cyc++;
        if (reset !== 1'b1) begin
            exp_q.delete();
            inflight.delete();
            last_due = 0;
        end else begin
            if (bus.imem_rvalid && inflight.size() > 0) begin
                r = inflight.pop_front();
                if (!bus.flush && r.epoch == epoch) begin
                    e.pc    = r.pc;
                    e.instr = r.pc ^ 8'hFF;
                    exp_q.push_back(e);
                end
            end
            if (bus.flush) begin
                exp_q.delete();
                epoch++;
                pc_m = flush_tgt;
            end else if (exp_req_v) begin
                lat      = int'($urandom_range(lat_max, lat_min));
                r.pc     = pc_m;
                r.epoch  = epoch;
                r.due    = (cyc - 1 + lat > last_due) ? cyc - 1 + lat : last_due + 1;
                last_due = r.due;
                inflight.push_back(r);
                pc_m = pc_m + 8'h01;
            end
        end

        bus.flush       = fl;
        flush_tgt       = tgt;
        bus.dec_ready   = rdy;
        bus.fetch_pc    = pc_m;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 8'($urandom);
        if (reset === 1'b1) begin
            if (inflight.size() > 0) begin
                if (inflight[0].due <= cyc) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = inflight[0].pc ^ 8'hFF;
                end
            end else if (int'($urandom_range(99)) < p_err) begin
                bus.imem_rvalid = 1'b1;
            end
        end
        exp_req_v = (reset === 1'b1) && !fl && (exp_q.size() + inflight.size() < DEPTH);
    endtask

    task automatic async_reset_check();
        #2;
        reset           = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.flush       = 1'b0;
        exp_q.delete();
        inflight.delete();
        last_due  = 0;
        exp_req_v = 1'b0;
        #1;
        check("rst_dec_valid", 8'(bus.dec_valid), 8'h00);
        check("rst_dec_instr", bus.dec_instr, 8'h00);
        check("rst_dec_pc", bus.dec_pc, 8'h00);
        check("rst_imem_req", 8'(bus.imem_req), 8'h00);
        check("rst_pc_hold", 8'(bus.pc_hold), 8'h01);
    endtask

    task automatic release_reset(input bit ghost);
        reset        = 1'b1;
        pc_m         = 8'h00;
        bus.fetch_pc = 8'h00;
        bus.flush    = 1'b0;
        if (ghost) begin
            // Late answer to a request issued before reset
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 8'hA5;
        end
        exp_req_v = (exp_q.size() + inflight.size() < DEPTH);
    endtask

    // Monitor: compare decoder and request outputs with the model each interval
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            exp_v = (exp_q.size() != 0);
            check("dec_valid", 8'(bus.dec_valid), 8'(exp_v));
            if (exp_v) begin
                check("dec_pc", bus.dec_pc, exp_q[0].pc);
                check("dec_instr", bus.dec_instr, exp_q[0].instr);
            end else if (reset !== 1'b1) begin
                check("dec_pc_in_reset", bus.dec_pc, 8'h00);
                check("dec_instr_in_reset", bus.dec_instr, 8'h00);
            end
            check("imem_req", 8'(bus.imem_req), 8'(exp_req_v));
            check("pc_hold", 8'(bus.pc_hold), 8'(!exp_req_v));
            if (exp_req_v) begin
                check("imem_addr", bus.imem_addr, bus.fetch_pc);
            end
            if (exp_v && bus.dec_ready && !bus.flush && reset === 1'b1) begin
                $display("cycle %0d decode pc=%h instr=%h", cyc, exp_q[0].pc, exp_q[0].instr);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        reset           = 1'b0;
        bus.fetch_pc    = 8'h00;
        bus.flush       = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 8'h00;
        bus.dec_ready   = 1'b0;

        repeat (3) cycle(1'b0, 1'b1, 8'h00);
        release_reset(1'b0);

        // Streaming with single-cycle memory
        lat_min = 1; lat_max = 1; p_err = 0;
        repeat (40) cycle(1'b0, 1'b1, 8'h00);

        // Backpressure until credit runs out, then drain
        repeat (12) cycle(1'b0, 1'b0, 8'h00);
        repeat (20) cycle(1'b0, 1'b1, 8'h00);

        // Flush with two requests in flight on a slow memory
        lat_min = 3; lat_max = 3;
        repeat (4) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h10);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h40);
        repeat (15) cycle(1'b0, 1'b1, 8'h00);

        // Flush together with a response and a decoder accept
        lat_min = 1; lat_max = 1;
        repeat (6) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h80);
        repeat (6) cycle(1'b0, 1'b1, 8'h00);

        // Random traffic, latencies, flushes and spurious responses
        lat_min = 1; lat_max = 4; p_err = 10;
        repeat (600) cycle(int'($urandom_range(99)) < 5, int'($urandom_range(99)) < 70, 8'($urandom));

        // Asynchronous reset with three entries buffered
        p_err = 0; lat_min = 2; lat_max = 2;
        n = 0;
        while (exp_q.size() < 3 && n < 30) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        checks++;
        if (exp_q.size() < 3) begin
            failures++;
            $display("FAIL fill_before_reset: got %0d entries expected 3 within 30 cycles", exp_q.size());
        end
        async_reset_check();
        repeat (3) cycle(1'b0, 1'b1, 8'h00);
        release_reset(1'b1);
        lat_min = 1; lat_max = 1;
        repeat (30) cycle(1'b0, 1'b1, 8'h00);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
